mouse_pos_sync: RTL and testbench
=================================

Name: mouse_pos_sync

Overview:
- Sits directly upstream of the mouse-drawing stage and supplies its xpos/ypos.
- Takes raw position samples from the mouse controller and holds the newest one in a staging register.
- Clamps the sample to the visible area and commits it to the outputs once per frame, at the vblank rising edge.
- The drawn cursor therefore never moves mid-frame and never leaves the screen.

Parameters:
- H_ACTIVE, 800, visible pixels per line.
- V_ACTIVE, 600, visible lines per frame.
- CURSOR_W, 16, cursor width in pixels; max committed x = H_ACTIVE-CURSOR_W.
- CURSOR_H, 16, cursor height in lines; max committed y = V_ACTIVE-CURSOR_H.

Ports:
- clk  in  1  pixel clock, shared with the vga_if pipeline.
- rst  in  1  synchronous, active-high reset.
- xpos_raw  in  12  mouse controller x, unsigned.
- ypos_raw  in  12  mouse controller y, unsigned.
- left_raw  in  1  mouse controller left button.
- mouse_valid  in  1  one-cycle strobe; raw inputs are valid in that cycle.
- vblnk  in  1  vertical blank from timing generator.
- xpos  out  12  committed x, feeds the draw stage.
- ypos  out  12  committed y, feeds the draw stage.
- left  out  1  committed left button.
- frame_update  out  1  one-cycle pulse when a new position is committed.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: xpos=0, ypos=0, left=0, frame_update=0, staging=0, pending=0, vblnk_d=0, state=IDLE.
- Staging: on mouse_valid=1, capture xpos_raw/ypos_raw/left_raw into staging and set pending=1. Every sample is captured; the newest sample overwrites older ones.
- Edge detect: vblnk_d <= vblnk. Edge cycle E is the cycle where vblnk=1 and vblnk_d=0.
- FSM states: IDLE, CLAMP, COMMIT.
  - IDLE -> CLAMP: edge in cycle E and pending=1. If pending=0 at E, stay in IDLE (no update, no pulse).
  - CLAMP (cycle E+1): register snapshot of clamped staging; clear pending.
  - COMMIT (cycle E+2): load xpos/ypos/left from snapshot; assert frame_update next cycle; -> IDLE.
- Latency: new xpos/ypos/left and frame_update=1 are visible in cycle E+3. frame_update is high for exactly one cycle.
- Clamping is unsigned, 12-bit compare:
  - x = min(xpos_raw, H_ACTIVE-CURSOR_W).
  - y = min(ypos_raw, V_ACTIVE-CURSOR_H).
- Simultaneous mouse_valid and pending clear in CLAMP: set wins; pending stays 1. The snapshot uses the pre-update staging value; the new sample is committed at the next frame.
- mouse_valid while in CLAMP or COMMIT: updates staging only; the in-flight commit is unaffected.
- vblnk held high for many cycles counts as one edge. A vblnk glitch (1 cycle) is a valid edge.
- A new edge while not in IDLE is ignored (impossible at legal timing).
- rst asserted mid-operation: all state returns to reset values on the next clock; an in-flight commit is dropped.

Optional Feature:
- Macro: MOUSE_POS_SMOOTH_EN.
- Defined: COMMIT loads xpos = (xpos + x_snap) >> 1, using a 13-bit sum truncated to 12 bits; same for ypos. left is unaffected. Cursor converges geometrically over frames. Values remain within clamp bounds.
- Undefined: direct load of the snapshot.

Decomposition:
- vga_pkg (existing): HOR_PIXELS/VER_PIXELS constants, used as parameter defaults.
- vga_pkg, new: typedef enum logic [1:0] {IDLE, CLAMP, COMMIT} mouse_sync_state_t; localparam MOUSE_CURSOR_SIZE = 16.
- One natural sub-module: pos_clamp, combinational min() of a 12-bit value against a 12-bit limit, instantiated for x and y.

Test Plan:
- Reset: hold rst 3 cycles with mouse_valid pulsing -> xpos=ypos=0, left=0, frame_update=0; no commit at the following vblank.
- Basic commit: mouse_valid with (100,200,left=1), then vblnk rises at cycle E -> xpos=100, ypos=200, left=1, frame_update=1 at exactly E+3; outputs are stable before E+3.
- Clamp: raw (1000,4095) -> committed (784,584); raw (784,584) -> unchanged.
- Multiple samples and no-pending: samples (10,10), (20,20), (30,30) in one frame -> commit (30,30); next frame with no mouse_valid -> no frame_update, outputs hold.
- Collision: mouse_valid (50,60) in the CLAMP cycle of a commit of (40,40) -> (40,40) committed this frame, (50,60) committed next frame.
- Mid-commit reset: rst asserted in cycle E+2 -> outputs 0, no frame_update. With MOUSE_POS_SMOOTH_EN: from 0, target 100 -> 50, 75, 87, 93 over successive frames.

Source files
------------

// File: rtl/mouse_pos_sync_pkg.sv
// mouse_pos_sync_pkg: screen geometry, cursor size and FSM state type for the mouse position sync stage.
package mouse_pos_sync_pkg;
   localparam int HOR_PIXELS        = 800;
   localparam int VER_PIXELS        = 600;
   localparam int MOUSE_CURSOR_SIZE = 16;
   typedef enum logic [1:0] {IDLE, CLAMP, COMMIT} mouse_sync_state_t;
endpackage

// File: rtl/mouse_pos_sync_clamp.sv
// pos_clamp: unsigned 12-bit min() of a value against a limit.
module pos_clamp (
   input  logic [11:0] val_i,
   input  logic [11:0] lim_i,
   output logic [11:0] val_o
);
   assign val_o = (val_i > lim_i) ? lim_i : val_i;
endmodule

// File: rtl/mouse_pos_sync.sv
// mouse_pos_sync: stage newest mouse sample, clamp it and commit once per frame at vblank rise.
// MOUSE_POS_SMOOTH_EN: commit averages old and new position instead of loading directly.
module mouse_pos_sync
   import mouse_pos_sync_pkg::*;
#(
   parameter int H_ACTIVE = HOR_PIXELS,
   parameter int V_ACTIVE = VER_PIXELS,
   parameter int CURSOR_W = MOUSE_CURSOR_SIZE,
   parameter int CURSOR_H = MOUSE_CURSOR_SIZE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] xpos_raw,
   input  logic [11:0] ypos_raw,
   input  logic        left_raw,
   input  logic        mouse_valid,
   input  logic        vblnk,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        left,
   output logic        frame_update
);
   localparam logic [11:0] X_MAX = 12'(H_ACTIVE - CURSOR_W);
   localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - CURSOR_H);

   mouse_sync_state_t state_q;
   logic [11:0] stg_x_q, stg_y_q, snap_x_q, snap_y_q, xpos_q, ypos_q;
   logic [11:0] clamp_x, clamp_y, next_x, next_y;
   logic        stg_l_q, snap_l_q, left_q, pending_q, vblnk_q, frame_update_q;

   pos_clamp u_clamp_x (.val_i(stg_x_q), .lim_i(X_MAX), .val_o(clamp_x));
   pos_clamp u_clamp_y (.val_i(stg_y_q), .lim_i(Y_MAX), .val_o(clamp_y));

`ifdef MOUSE_POS_SMOOTH_EN
   logic [12:0] sum_x, sum_y;
   assign sum_x  = {1'b0, xpos_q} + {1'b0, snap_x_q};
   assign sum_y  = {1'b0, ypos_q} + {1'b0, snap_y_q};
   assign next_x = sum_x[12:1];
   assign next_y = sum_y[12:1];
`else
   assign next_x = snap_x_q;
   assign next_y = snap_y_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         stg_x_q        <= '0;
         stg_y_q        <= '0;
         stg_l_q        <= 1'b0;
         snap_x_q       <= '0;
         snap_y_q       <= '0;
         snap_l_q       <= 1'b0;
         xpos_q         <= '0;
         ypos_q         <= '0;
         left_q         <= 1'b0;
         pending_q      <= 1'b0;
         vblnk_q        <= 1'b0;
         frame_update_q <= 1'b0;
      end else begin
         vblnk_q        <= vblnk;
         frame_update_q <= 1'b0;
         if (mouse_valid) begin
            stg_x_q <= xpos_raw;
            stg_y_q <= ypos_raw;
            stg_l_q <= left_raw;
         end
         // a sample arriving in CLAMP keeps pending set for the next frame
         pending_q <= mouse_valid | (pending_q & (state_q != CLAMP));
         case (state_q)
            IDLE: if (vblnk && !vblnk_q && pending_q) state_q <= CLAMP;
            CLAMP: begin
               snap_x_q <= clamp_x;
               snap_y_q <= clamp_y;
               snap_l_q <= stg_l_q;
               state_q  <= COMMIT;
            end
            COMMIT: begin
               xpos_q         <= next_x;
               ypos_q         <= next_y;
               left_q         <= snap_l_q;
               frame_update_q <= 1'b1;
               state_q        <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign xpos         = xpos_q;
   assign ypos         = ypos_q;
   assign left         = left_q;
   assign frame_update = frame_update_q;
endmodule

// File: tb/tb_mouse_pos_sync.sv
// tb_mouse_pos_sync: random and directed stimulus checked every cycle against a behavioural model.
module tb_mouse_pos_sync;
   logic        clk = 1'b0, rst = 1'b1;
   logic [11:0] xpos_raw = '0, ypos_raw = '0, xpos, ypos;
   logic        left_raw = 1'b0, mouse_valid = 1'b0, vblnk = 1'b0, left, frame_update;
   int          tests = 0, fails = 0;
   bit          check_en = 1'b0;

`ifdef MOUSE_POS_SMOOTH_EN
   localparam bit SM = 1'b1;
`else
   localparam bit SM = 1'b0;
`endif

   mouse_pos_sync dut (
      .clk(clk), .rst(rst), .xpos_raw(xpos_raw), .ypos_raw(ypos_raw), .left_raw(left_raw),
      .mouse_valid(mouse_valid), .vblnk(vblnk), .xpos(xpos), .ypos(ypos), .left(left),
      .frame_update(frame_update)
   );

   always #5 clk = ~clk;

   // model: newest sample waits; a vblank rise with something waiting commits it 3 cycles later
   int m_x, m_y, s_x, s_y, snx, sny, cnt;
   bit m_l, m_fu, s_l, snl, pend, pv, rise;

   function automatic int upd(int o, int s);
      return SM ? (o + s) / 2 : s;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_x = 0; m_y = 0; m_l = 0; m_fu = 0; s_x = 0; s_y = 0; s_l = 0;
         pend = 0; pv = 0; cnt = 0;
      end else begin
         rise = vblnk && !pv;
         pv   = vblnk;
         m_fu = 0;
         if (cnt == 1) begin
            m_x = upd(m_x, snx); m_y = upd(m_y, sny); m_l = snl; m_fu = 1; cnt = 0;
         end else if (cnt == 2) begin
            snx = (s_x < 784) ? s_x : 784; sny = (s_y < 584) ? s_y : 584; snl = s_l;
            pend = 0; cnt = 1;
         end else if (rise && pend) cnt = 2;
         if (mouse_valid) begin
            s_x = xpos_raw; s_y = ypos_raw; s_l = left_raw; pend = 1;
         end
      end
   end

   always @(negedge clk) if (check_en) begin
      tests++;
      if ({xpos, ypos, left, frame_update} !== {12'(m_x), 12'(m_y), m_l, m_fu}) begin
         fails++;
         $display("FAIL cycle t=%0t: got x=%0d y=%0d l=%b fu=%b, want x=%0d y=%0d l=%b fu=%b",
                  $time, xpos, ypos, left, frame_update, m_x, m_y, m_l, m_fu);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic lit(string n, int ex, int ey, bit el, bit ef);
      tests++;
      if ({xpos, ypos, left, frame_update} !== {12'(ex), 12'(ey), el, ef}) begin
         fails++;
         $display("FAIL %s: got x=%0d y=%0d l=%b fu=%b, want x=%0d y=%0d l=%b fu=%b",
                  n, xpos, ypos, left, frame_update, ex, ey, el, ef);
      end
      tests++;
      if (m_x != ex || m_y != ey || m_l != el || m_fu != ef) begin
         fails++;
         $display("FAIL %s model: got x=%0d y=%0d l=%b fu=%b, want x=%0d y=%0d l=%b fu=%b",
                  n, m_x, m_y, m_l, m_fu, ex, ey, el, ef);
      end
   endtask

   task automatic sample(int x, int y, bit l);
      xpos_raw = 12'(x); ypos_raw = 12'(y); left_raw = l; mouse_valid = 1'b1;
      tick();
      mouse_valid = 1'b0;
   endtask

   task automatic frame(int hi);
      vblnk = 1'b1;
      repeat (hi) tick();
      vblnk = 1'b0;
      repeat (6) tick();
   endtask

   task automatic reset_dut();
      rst = 1'b1; tick(); rst = 1'b0; tick();
   endtask

   initial begin
      int sx[4] = '{50, 75, 87, 93};
      tick();
      check_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mouse_valid = i[0] ? 1'b0 : 1'b1; xpos_raw = 12'd500; ypos_raw = 12'd500; left_raw = 1'b1;
         tick();
      end
      rst = 1'b0; mouse_valid = 1'b0;
      lit("reset", 0, 0, 0, 0);
      tick();
      frame(4);
      lit("no_commit_after_reset", 0, 0, 0, 0);

      sample(100, 200, 1);
      repeat (3) tick();
      vblnk = 1'b1;
      tick(); tick();
      lit("stable_before_E3", 0, 0, 0, 0);
      tick();
      lit("basic_commit", SM ? 50 : 100, SM ? 100 : 200, 1, 1);
      tick();
      lit("pulse_one_cycle", SM ? 50 : 100, SM ? 100 : 200, 1, 0);
      repeat (8) tick();
      vblnk = 1'b0;
      repeat (6) tick();

      reset_dut();
      sample(1000, 4095, 0);
      frame(2);
      lit("clamp_high", SM ? 392 : 784, SM ? 292 : 584, 0, 0);
      reset_dut();
      sample(784, 584, 1);
      frame(1);
      lit("clamp_boundary", SM ? 392 : 784, SM ? 292 : 584, 1, 0);

      reset_dut();
      sample(10, 10, 0); tick(); sample(20, 20, 1); sample(30, 30, 0);
      frame(3);
      lit("newest_wins", SM ? 15 : 30, SM ? 15 : 30, 0, 0);
      vblnk = 1'b1;
      repeat (3) tick();
      lit("no_pending_no_pulse", SM ? 15 : 30, SM ? 15 : 30, 0, 0);
      vblnk = 1'b0;
      repeat (5) tick();

      reset_dut();
      sample(40, 40, 1);
      tick();
      vblnk = 1'b1;
      tick();
      sample(50, 60, 0);
      tick();
      lit("collision_old", SM ? 20 : 40, SM ? 20 : 40, 1, 1);
      vblnk = 1'b0;
      repeat (5) tick();
      frame(2);
      lit("collision_new", SM ? 35 : 50, SM ? 40 : 60, 0, 0);

      sample(300, 300, 1);
      vblnk = 1'b1;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lit("mid_commit_reset", 0, 0, 0, 0);
      tick();
      lit("mid_commit_reset_nopulse", 0, 0, 0, 0);
      vblnk = 1'b0;
      repeat (5) tick();

      for (int f = 0; f < 4; f++) begin
         sample(100, 100, 0);
         frame(2);
         lit("converge", SM ? sx[f] : 100, SM ? sx[f] : 100, 0, 0);
      end

      for (int f = 0; f < 300; f++) begin
         int lo = $urandom_range(8, 30);
         int hi = $urandom_range(1, 12);
         for (int c = 0; c < lo + hi; c++) begin
            vblnk       = (c >= lo);
            mouse_valid = ($urandom_range(0, 3) == 0);
            xpos_raw    = 12'($urandom_range(0, 4095));
            ypos_raw    = 12'($urandom_range(0, 4095));
            left_raw    = 1'($urandom_range(0, 1));
            rst         = ($urandom_range(0, 399) == 0);
            tick();
         end
      end
      rst = 1'b0; mouse_valid = 1'b0; vblnk = 1'b0;
      repeat (5) tick();
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
